ball_collision_detector: RTL and testbench
==========================================

# ball_collision_detector

Per-frame collision detector between the ball sprite and the playfield layers produced by the background drawing stage. It sits directly downstream of the background draw block and beside the ball drawing block. Each pixel clock it ANDs the ball draw request with every background draw-request flag and accumulates hit flags, a border hit bounding box and a border hit count. At each start of frame it publishes one registered snapshot with a one-cycle valid pulse for the ball motion controller.

## Interface
Parameters:
- `BALL_DELAY`, default 1. Number of cycles by which `ballDR` and `pixelX`/`pixelY` are delayed so they line up with the registered background flags.
- `COUNT_W`, default 12. Width of the border hit counter.

Ports:
- `clk`  in  1. Pixel clock.
- `reset`  in  1. Synchronous, active-high.
- `startOfFrame`  in  1. One-cycle pulse at the first pixel of each frame.
- `pixelX`, `pixelY`  in  11 each. Current scan coordinates, undelayed.
- `ballDR`  in  1. Ball draw request, aligned to undelayed `pixelX`/`pixelY`.
- `boardersDrawReq`, `diagonalBoarderDrawReq`, `oneSidedBorderDR`, `lossDR`, `teleportDR`, `speedVarDR`  in  1 each. Background flags, registered one cycle after their pixel.
- `topleftX`, `topleftY`  in  11 each. 32-pixel tile origin, registered with the flags.
- `collisionValid`  out  1. One-cycle pulse when the snapshot updates.
- `hitBorder`, `hitDiagonal`, `hitOneSided`, `hitLoss`, `hitTeleport`, `hitSpeed`  out  1 each. Sticky for the whole previous frame.
- `borderMinX`, `borderMaxX`, `borderMinY`, `borderMaxY`  out  11 each. Bounding box of border hit pixels.
- `borderHitCount`  out  `COUNT_W`. Saturating count of border hit pixels.
- `teleportTileX`, `teleportTileY`  out  11 each. `topleftX`/`topleftY` at the first teleport hit of the frame.

## Operation
- Delay line: `ballDR`, `pixelX` and `pixelY` pass through a `BALL_DELAY`-deep register shift. The delayed values are `ballDR_d`, `px_d` and `py_d`.
- Hit condition per category: `ballDR_d && flag`.
- A border pixel is `ballDR_d && (boardersDrawReq || diagonalBoarderDrawReq)`.
- Accumulators, cleared on frame start:
  - six sticky hit bits;
  - `minX`/`minY` start at 2047, `maxX`/`maxY` start at 0;
  - count starts at 0;
  - teleport tile capture is armed.
- On a border pixel:
  - `minX = min(minX, px_d)`, and likewise for `maxX`, `minY` and `maxY`;
  - count increments and saturates at 2^COUNT_W−1.
- Teleport tile: captured on the first teleport hit of the frame only. Later hits in the same frame are ignored.
- FSM states are `WAIT_FRAME`, `ACCUM` and `REPORT`.
  - `WAIT_FRAME`: entered at reset. The block ignores all hits until the first `startOfFrame`.
  - On `startOfFrame` in any state: snapshot the accumulators to the outputs, clear the accumulators, then go to `REPORT`. From `WAIT_FRAME` it clears the accumulators and goes to `ACCUM` with no snapshot and no valid pulse.
  - `REPORT`: asserts `collisionValid` for this single cycle, accumulates as normal, then goes to `ACCUM`.
  - `ACCUM`: accumulates and waits for `startOfFrame`.
- Empty frame (count = 0): the box outputs are forced to 0, not 2047.
- Frame overlap: a hit whose delayed pixel falls in the `startOfFrame` cycle belongs to the new frame. The clear takes priority and the hit is then applied to the cleared value in the same cycle.
- A second `startOfFrame` arriving while in `REPORT` is handled as a normal frame start. The result is a fresh snapshot, which is empty, plus another valid pulse.

## Timing
- If `startOfFrame` is high in cycle t, the snapshot outputs change at the t+1 edge and `collisionValid` is high during t+1 only.
- Outputs are held constant between snapshots.
- A ball pixel presented at cycle t is accumulated at t+`BALL_DELAY`.
- Reset takes effect on the next edge:
  - all outputs go to 0, including `collisionValid`;
  - the delay line clears;
  - the state goes to `WAIT_FRAME`.
- Reset mid-frame discards that frame's partial results.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `pinball_collision_pkg` holds:
  - the state enum `coll_state_t`;
  - `COORD_W = 11`;
  - `COORD_MAX = 11'd2047`;
  - `TILE_SIZE = 32`.
- Sub-module `hit_bbox_accum` holds the min/max box plus the saturating counter. Its ports are `clear`, `en`, `x`, `y`, box outputs and count. It is instantiated once, for border hits.
- The delay line, sticky bits, teleport capture and FSM stay in the top module.

## Test plan
- Reset, then the first frame with ball pixels on a border → no `collisionValid` for that frame; all outputs remain 0 until the second `startOfFrame`.
- Ball pixels (200..215, 40..55) all inside `boardersDrawReq` → at the next frame start: `hitBorder` = 1, box = (200, 215, 40, 55), count = 256, `collisionValid` high for exactly 1 cycle.
- Ball overlaps `teleportDR` at pixels (330,330) then (340,335), with tile origin 320,320 → `hitTeleport` = 1, `teleportTileX/Y` = 320/320; the second hit does not alter the capture.
- Frame with no overlaps but `lossDR` hit at (300,471) → `hitLoss` = 1, other bits 0, box outputs 0, count 0.
- 5000 border hit pixels in one frame → `borderHitCount` = 4095.
- Ball hit whose delayed pixel coincides with `startOfFrame` → hit appears in the following snapshot, not the current one; assert `reset` mid-frame → outputs 0 at the next edge and the FSM is in `WAIT_FRAME`.

Source files
------------

// File: rtl/pinball_collision_pkg.sv
// Shared types and constants for the ball collision detector.
package pinball_collision_pkg;

  localparam int unsigned COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_MAX = 11'd2047;
  localparam int unsigned TILE_SIZE = 32;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    REPORT     = 2'd2
  } coll_state_t;

endpackage

// File: rtl/hit_bbox_accum.sv
// Per-frame bounding box of hit pixels plus a saturating hit counter.
import pinball_collision_pkg::*;

module hit_bbox_accum #(
  parameter int unsigned COUNT_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] min_x,
  output logic [COORD_W-1:0] max_x,
  output logic [COORD_W-1:0] min_y,
  output logic [COORD_W-1:0] max_y,
  output logic [COUNT_W-1:0] count
);

  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [COUNT_W-1:0] r_count;

  logic [COORD_W-1:0] w_min_x_base, w_max_x_base, w_min_y_base, w_max_y_base;
  logic [COUNT_W-1:0] w_cnt_base;

  // Clear wins over the held value; a same-cycle hit then updates the cleared value
  always_comb begin
    w_min_x_base = clear ? COORD_MAX : r_min_x;
    w_min_y_base = clear ? COORD_MAX : r_min_y;
    w_max_x_base = clear ? '0 : r_max_x;
    w_max_y_base = clear ? '0 : r_max_y;
    w_cnt_base   = clear ? '0 : r_count;
  end

  // Box and counter update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_min_x <= COORD_MAX;
      r_min_y <= COORD_MAX;
      r_max_x <= '0;
      r_max_y <= '0;
      r_count <= '0;
    end else begin
      r_min_x <= (en && (x < w_min_x_base)) ? x : w_min_x_base;
      r_min_y <= (en && (y < w_min_y_base)) ? y : w_min_y_base;
      r_max_x <= (en && (x > w_max_x_base)) ? x : w_max_x_base;
      r_max_y <= (en && (y > w_max_y_base)) ? y : w_max_y_base;
      r_count <= (en && (w_cnt_base != '1)) ? w_cnt_base + COUNT_W'(1) : w_cnt_base;
    end
  end

  assign min_x = r_min_x;
  assign max_x = r_max_x;
  assign min_y = r_min_y;
  assign max_y = r_max_y;
  assign count = r_count;

endmodule

// File: rtl/ball_collision_detector.sv
// Per-frame ball vs. playfield collision accumulator with a registered snapshot at frame start.
import pinball_collision_pkg::*;

module ball_collision_detector #(
  parameter int unsigned BALL_DELAY = 1,
  parameter int unsigned COUNT_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               ballDR,
  input  logic               boardersDrawReq,
  input  logic               diagonalBoarderDrawReq,
  input  logic               oneSidedBorderDR,
  input  logic               lossDR,
  input  logic               teleportDR,
  input  logic               speedVarDR,
  input  logic [COORD_W-1:0] topleftX,
  input  logic [COORD_W-1:0] topleftY,
  output logic               collisionValid,
  output logic               hitBorder,
  output logic               hitDiagonal,
  output logic               hitOneSided,
  output logic               hitLoss,
  output logic               hitTeleport,
  output logic               hitSpeed,
  output logic [COORD_W-1:0] borderMinX,
  output logic [COORD_W-1:0] borderMaxX,
  output logic [COORD_W-1:0] borderMinY,
  output logic [COORD_W-1:0] borderMaxY,
  output logic [COUNT_W-1:0] borderHitCount,
  output logic [COORD_W-1:0] teleportTileX,
  output logic [COORD_W-1:0] teleportTileY
);

  localparam int unsigned N_HIT = 6;

  // Delay line aligning the ball request and coordinates with the registered background flags
  logic               r_ball_sr [BALL_DELAY];
  logic [COORD_W-1:0] r_px_sr   [BALL_DELAY];
  logic [COORD_W-1:0] r_py_sr   [BALL_DELAY];

  logic               w_ball_d;
  logic [COORD_W-1:0] w_px_d, w_py_d;

  coll_state_t r_state, w_state_nxt;
  logic        w_accum_en, w_clear, w_snap;

  logic [N_HIT-1:0]   w_flags, w_hit;
  logic               w_border_px;
  logic [N_HIT-1:0]   r_hit_acc;
  logic               r_tele_armed, w_tele_armed_base;
  logic [COORD_W-1:0] r_tele_x, r_tele_y;

  logic [COORD_W-1:0] w_acc_min_x, w_acc_max_x, w_acc_min_y, w_acc_max_y;
  logic [COUNT_W-1:0] w_acc_count;

  logic               r_valid;
  logic [N_HIT-1:0]   r_hit_out;
  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [COUNT_W-1:0] r_count;
  logic [COORD_W-1:0] r_tile_x, r_tile_y;

  // Shift register for ballDR and pixel coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BALL_DELAY); i++) begin
        r_ball_sr[i] <= 1'b0;
        r_px_sr[i]   <= '0;
        r_py_sr[i]   <= '0;
      end
    end else begin
      r_ball_sr[0] <= ballDR;
      r_px_sr[0]   <= pixelX;
      r_py_sr[0]   <= pixelY;
      for (int i = 1; i < int'(BALL_DELAY); i++) begin
        r_ball_sr[i] <= r_ball_sr[i-1];
        r_px_sr[i]   <= r_px_sr[i-1];
        r_py_sr[i]   <= r_py_sr[i-1];
      end
    end
  end

  assign w_ball_d = r_ball_sr[BALL_DELAY-1];
  assign w_px_d   = r_px_sr[BALL_DELAY-1];
  assign w_py_d   = r_py_sr[BALL_DELAY-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_FRAME;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and frame control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accum_en  = 1'b0;
    w_clear     = 1'b0;
    w_snap      = 1'b0;
    case (r_state)
      WAIT_FRAME: begin
        if (startOfFrame) begin
          w_clear     = 1'b1;
          w_accum_en  = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        w_accum_en = 1'b1;
        if (startOfFrame) begin
          w_clear     = 1'b1;
          w_snap      = 1'b1;
          w_state_nxt = REPORT;
        end
      end
      REPORT: begin
        w_accum_en = 1'b1;
        if (startOfFrame) begin
          w_clear     = 1'b1;
          w_snap      = 1'b1;
          w_state_nxt = REPORT;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = WAIT_FRAME;
    endcase
  end

  // Per-category hit detection, ignored until the first frame start
  always_comb begin
    w_flags     = {speedVarDR, teleportDR, lossDR, oneSidedBorderDR,
                   diagonalBoarderDrawReq, boardersDrawReq};
    w_hit       = (w_accum_en && w_ball_d) ? w_flags : '0;
    w_border_px = w_hit[0] || w_hit[1];
    w_tele_armed_base = w_clear ? 1'b1 : r_tele_armed;
  end

  // Sticky hit bits and first-teleport tile capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_acc    <= '0;
      r_tele_armed <= 1'b1;
      r_tele_x     <= '0;
      r_tele_y     <= '0;
    end else begin
      r_hit_acc <= (w_clear ? '0 : r_hit_acc) | w_hit;
      if (w_hit[4] && w_tele_armed_base) begin
        r_tele_armed <= 1'b0;
        r_tele_x     <= topleftX;
        r_tele_y     <= topleftY;
      end else begin
        r_tele_armed <= w_tele_armed_base;
        r_tele_x     <= w_clear ? '0 : r_tele_x;
        r_tele_y     <= w_clear ? '0 : r_tele_y;
      end
    end
  end

  hit_bbox_accum #(
    .COUNT_W (COUNT_W)
  ) u_border_accum (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_border_px),
    .x     (w_px_d),
    .y     (w_py_d),
    .min_x (w_acc_min_x),
    .max_x (w_acc_max_x),
    .min_y (w_acc_min_y),
    .max_y (w_acc_max_y),
    .count (w_acc_count)
  );

  // Snapshot register; an empty frame reports a zero box
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_hit_out <= '0;
      r_min_x   <= '0;
      r_max_x   <= '0;
      r_min_y   <= '0;
      r_max_y   <= '0;
      r_count   <= '0;
      r_tile_x  <= '0;
      r_tile_y  <= '0;
    end else begin
      r_valid <= w_snap;
      if (w_snap) begin
        r_hit_out <= r_hit_acc;
        r_count   <= w_acc_count;
        r_tile_x  <= r_tele_x;
        r_tile_y  <= r_tele_y;
        if (w_acc_count == '0) begin
          r_min_x <= '0;
          r_max_x <= '0;
          r_min_y <= '0;
          r_max_y <= '0;
        end else begin
          r_min_x <= w_acc_min_x;
          r_max_x <= w_acc_max_x;
          r_min_y <= w_acc_min_y;
          r_max_y <= w_acc_max_y;
        end
      end
    end
  end

  assign collisionValid = r_valid;
  assign hitBorder      = r_hit_out[0];
  assign hitDiagonal    = r_hit_out[1];
  assign hitOneSided    = r_hit_out[2];
  assign hitLoss        = r_hit_out[3];
  assign hitTeleport    = r_hit_out[4];
  assign hitSpeed       = r_hit_out[5];
  assign borderMinX     = r_min_x;
  assign borderMaxX     = r_max_x;
  assign borderMinY     = r_min_y;
  assign borderMaxY     = r_max_y;
  assign borderHitCount = r_count;
  assign teleportTileX  = r_tile_x;
  assign teleportTileY  = r_tile_y;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Self-checking bench for ball_collision_detector: frame table plus hand-written corner sequences.
module tb_ball_collision_detector;
  import pinball_collision_pkg::*;

  localparam int unsigned CW = 12;

  typedef struct packed {
    logic [5:0]  hits;   // {speed, teleport, loss, oneSided, diagonal, border}
    logic [10:0] min_x;
    logic [10:0] max_x;
    logic [10:0] min_y;
    logic [10:0] max_y;
    logic [CW-1:0] count;
    logic [10:0] tile_x;
    logic [10:0] tile_y;
  } snap_t;

  typedef struct {
    int         x0, x1, y0, y1;
    logic [5:0] flags;
    snap_t      exp;
  } frame_vec_t;

  logic clk, reset, startOfFrame, ballDR;
  logic [10:0] pixelX, pixelY, topleftX, topleftY;
  logic boardersDrawReq, diagonalBoarderDrawReq, oneSidedBorderDR, lossDR, teleportDR, speedVarDR;
  logic collisionValid, hitBorder, hitDiagonal, hitOneSided, hitLoss, hitTeleport, hitSpeed;
  logic [10:0] borderMinX, borderMaxX, borderMinY, borderMaxY, teleportTileX, teleportTileY;
  logic [CW-1:0] borderHitCount;

  ball_collision_detector #(.BALL_DELAY(1), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .ballDR(ballDR),
    .boardersDrawReq(boardersDrawReq), .diagonalBoarderDrawReq(diagonalBoarderDrawReq),
    .oneSidedBorderDR(oneSidedBorderDR), .lossDR(lossDR), .teleportDR(teleportDR),
    .speedVarDR(speedVarDR), .topleftX(topleftX), .topleftY(topleftY),
    .collisionValid(collisionValid), .hitBorder(hitBorder), .hitDiagonal(hitDiagonal),
    .hitOneSided(hitOneSided), .hitLoss(hitLoss), .hitTeleport(hitTeleport), .hitSpeed(hitSpeed),
    .borderMinX(borderMinX), .borderMaxX(borderMaxX), .borderMinY(borderMinY),
    .borderMaxY(borderMaxY), .borderHitCount(borderHitCount),
    .teleportTileX(teleportTileX), .teleportTileY(teleportTileY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  snap_t exp_q[$];
  snap_t cur_exp;
  logic [5:0]  prev_flags;
  logic [10:0] prev_tlx, prev_tly;
  bit armed;
  frame_vec_t vecs[6];

  localparam logic [5:0] F_BORDER = 6'b000001;
  localparam logic [5:0] F_DIAG   = 6'b000010;
  localparam logic [5:0] F_ONE    = 6'b000100;
  localparam logic [5:0] F_LOSS   = 6'b001000;
  localparam logic [5:0] F_TELE   = 6'b010000;
  localparam logic [5:0] F_SPEED  = 6'b100000;

  function automatic snap_t mk(input logic [5:0] h, input int mnx, input int mxx,
                               input int mny, input int mxy, input int n,
                               input int tx, input int ty);
    snap_t s;
    s.hits   = h;
    s.min_x  = 11'(mnx);
    s.max_x  = 11'(mxx);
    s.min_y  = 11'(mny);
    s.max_y  = 11'(mxy);
    s.count  = CW'(n);
    s.tile_x = 11'(tx);
    s.tile_y = 11'(ty);
    return s;
  endfunction

  task automatic check_snap(input string nm, input snap_t a, input snap_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got hits=%b box=%0d,%0d,%0d,%0d cnt=%0d tile=%0d,%0d required hits=%b box=%0d,%0d,%0d,%0d cnt=%0d tile=%0d,%0d",
               nm, $time, a.hits, a.min_x, a.max_x, a.min_y, a.max_y, a.count, a.tile_x, a.tile_y,
               e.hits, e.min_x, e.max_x, e.min_y, e.max_y, e.count, e.tile_x, e.tile_y);
    end
  endtask

  task automatic check_bit(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t got %b required %b", nm, $time, a, e);
    end
  endtask

  // Drive one pixel; background flags for the previous pixel arrive alongside it
  task automatic step(input logic b, input int x, input int y, input logic [5:0] f, input logic sof);
    @(negedge clk);
    startOfFrame = sof;
    ballDR = b;
    pixelX = 11'(x);
    pixelY = 11'(y);
    {speedVarDR, teleportDR, lossDR, oneSidedBorderDR, diagonalBoarderDrawReq, boardersDrawReq} = prev_flags;
    topleftX = prev_tlx;
    topleftY = prev_tly;
    prev_flags = f;
    prev_tlx = 11'((x / int'(TILE_SIZE)) * int'(TILE_SIZE));
    prev_tly = 11'((y / int'(TILE_SIZE)) * int'(TILE_SIZE));
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 6'h0, 1'b0);
  endtask

  task automatic frame_start(input snap_t e);
    if (armed) exp_q.push_back(e);
    armed = 1'b1;
    step(1'b0, 0, 0, 6'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    startOfFrame = 1'b0;
    ballDR = 1'b0;
    {speedVarDR, teleportDR, lossDR, oneSidedBorderDR, diagonalBoarderDrawReq, boardersDrawReq} = 6'h0;
    prev_flags = 6'h0;
    cur_exp = '0;
    armed = 1'b0;
    @(negedge clk);
    check_bit("reset_valid", collisionValid, 1'b0);
    reset = 1'b0;
  endtask

  // Scoreboard: pop on every valid pulse, otherwise outputs must hold the last snapshot
  always @(posedge clk) begin
    snap_t act;
    #1;
    act = {hitSpeed, hitTeleport, hitLoss, hitOneSided, hitDiagonal, hitBorder,
           borderMinX, borderMaxX, borderMinY, borderMaxY, borderHitCount,
           teleportTileX, teleportTileY};
    if (collisionValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid t=%0t got valid=1 required valid=0", $time);
      end else begin
        snap_t e;
        e = exp_q.pop_front();
        check_snap("snapshot", act, e);
        cur_exp = e;
      end
    end else begin
      check_snap("hold", act, cur_exp);
    end
  end

  initial begin
    vecs[0] = '{x0:200,  x1:215,  y0:40,   y1:55,   flags:F_BORDER,
                exp:mk(6'b000001, 200, 215, 40, 55, 256, 0, 0)};
    vecs[1] = '{x0:300,  x1:300,  y0:471,  y1:471,  flags:F_LOSS,
                exp:mk(6'b001000, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{x0:100,  x1:103,  y0:10,   y1:11,   flags:F_DIAG | F_SPEED,
                exp:mk(6'b100010, 100, 103, 10, 11, 8, 0, 0)};
    vecs[3] = '{x0:5,    x1:5,    y0:5,    y1:5,    flags:F_ONE,
                exp:mk(6'b000100, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{x0:50,   x1:51,   y0:60,   y1:60,   flags:6'h0,
                exp:mk(6'b000000, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5] = '{x0:1000, x1:1003, y0:2000, y1:2001, flags:F_BORDER | F_TELE,
                exp:mk(6'b010001, 1000, 1003, 2000, 2001, 8, 992, 1984)};

    reset = 1'b1;
    startOfFrame = 1'b0;
    ballDR = 1'b0;
    pixelX = '0; pixelY = '0; topleftX = '0; topleftY = '0;
    {speedVarDR, teleportDR, lossDR, oneSidedBorderDR, diagonalBoarderDrawReq, boardersDrawReq} = 6'h0;
    prev_flags = 6'h0; prev_tlx = '0; prev_tly = '0;
    cur_exp = '0;
    armed = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_valid", collisionValid, 1'b0);
    reset = 1'b0;

    // Border hits before the first frame start are ignored; first frame start reports nothing
    for (int i = 0; i < 10; i++) step(1'b1, 200 + i, 40, F_BORDER, 1'b0);
    idle();
    frame_start('0);
    repeat (3) idle();

    // Table of single-rectangle frames, each preceded by a flag-only pixel with no ball
    for (int v = 0; v < 6; v++) begin
      step(1'b0, vecs[v].x0, vecs[v].y0, 6'h3F, 1'b0);
      for (int y = vecs[v].y0; y <= vecs[v].y1; y++)
        for (int x = vecs[v].x0; x <= vecs[v].x1; x++)
          step(1'b1, x, y, vecs[v].flags, 1'b0);
      idle();
      frame_start(vecs[v].exp);
      idle();
    end

    // Only the first teleport hit of a frame is captured
    step(1'b1, 330, 330, F_TELE, 1'b0);
    step(1'b1, 340, 335, F_TELE, 1'b0);
    step(1'b1, 400, 400, F_TELE, 1'b0);
    idle();
    frame_start(mk(6'b010000, 0, 0, 0, 0, 0, 320, 320));
    idle();

    // Counter saturation with 5000 border pixels
    for (int i = 0; i < 5000; i++) step(1'b1, 100 + (i % 50), 100 + (i / 50), F_BORDER, 1'b0);
    idle();
    frame_start(mk(6'b000001, 100, 149, 100, 199, 4095, 0, 0));
    idle();

    // Delayed hit landing on the frame-start cycle belongs to the new frame
    step(1'b1, 500, 500, F_BORDER, 1'b0);
    frame_start(mk(6'b000000, 0, 0, 0, 0, 0, 0, 0));
    idle();
    frame_start(mk(6'b000001, 500, 500, 500, 500, 1, 0, 0));
    // Back-to-back frame start while reporting yields a fresh empty snapshot
    frame_start(mk(6'b000000, 0, 0, 0, 0, 0, 0, 0));
    idle();

    step(1'b1, 700, 710, F_BORDER, 1'b0);
    idle();
    frame_start(mk(6'b000001, 700, 700, 710, 710, 1, 0, 0));
    idle();

    // Mid-frame reset discards partial results and returns to waiting for a frame
    step(1'b1, 800, 800, F_BORDER, 1'b0);
    step(1'b1, 801, 800, F_BORDER | F_LOSS, 1'b0);
    do_reset();
    step(1'b1, 900, 900, F_BORDER, 1'b0);
    idle();
    frame_start('0);
    step(1'b1, 10, 20, F_BORDER, 1'b0);
    idle();
    frame_start(mk(6'b000001, 10, 10, 20, 20, 1, 0, 0));
    repeat (4) idle();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_snapshots got %0d outstanding required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
